// File: rtl/data_buffer_pkg.sv
// Shared defaults and helpers for the parametrised USB/AHB byte FIFO.
package data_buffer_pkg;

    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_WORD_BYTES = 4;
    localparam int OCC_W              = $clog2(DEFAULT_DEPTH) + 1;
    localparam int SZ_W               = $clog2(DEFAULT_WORD_BYTES);

    function automatic int unsigned size_to_bytes(input int unsigned dataSize);
        return dataSize + 1;
    endfunction

endpackage

// File: rtl/data_buffer_param_mb_byte_ram.sv
// DEPTH x 8 storage with a multi-byte write port and a multi-byte combinational
// read port; addresses wrap modulo DEPTH through pointer-width truncation.
module mb_byte_ram
    import data_buffer_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(WORD_BYTES) + 1
) (
    input  logic                    clk,
    input  logic                    wrEn_i,
    input  logic [PTR_W-1:0]        wrPtr_i,
    input  logic [CNT_W-1:0]        wrCount_i,
    input  logic [8*WORD_BYTES-1:0] wrWord_i,
    input  logic [PTR_W-1:0]        rdPtr_i,
    output logic [8*WORD_BYTES-1:0] rdWord_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte k of the word lands at base+k, so the low byte is written first.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (CNT_W'(k) < wrCount_i) begin
                    mem_q[wrPtr_i + PTR_W'(k)] <= wrWord_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rdWord_o = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rdWord_o[8*k +: 8] = mem_q[rdPtr_i + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/data_buffer_param.sv
// Byte FIFO between the USB packet engines (byte-wide) and the AHB slave
// (1..WORD_BYTES bytes per access), with sticky error reporting.
module data_buffer_param
    import data_buffer_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int OCC_W      = $clog2(DEPTH) + 1,
    parameter int SZ_W       = $clog2(WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    get_rx_data,
    input  logic [SZ_W-1:0]         data_size,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    store_tx_data,
    input  logic                    get_tx_packet_data,
    input  logic                    buffer_reserved,
    output logic [OCC_W-1:0]        buffer_occupancy,
    output logic                    full,
    output logic                    empty,
    output logic [8*WORD_BYTES-1:0] rx_data,
    output logic [7:0]              tx_packet_data,
    output logic                    overflow_err,
    output logic                    underflow_err,
    output logic                    conflict_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WORD_BYTES) + 1;
    localparam int DW    = 8 * WORD_BYTES;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DW-1:0]    rxData_q, rxData_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             conflict_q, conflict_d;

    logic             wordPush, bytePush, pushReq, pushOk;
    logic             wordPop, bytePop, popReq, popOk;
    logic [CNT_W-1:0] wordCnt, pushCnt, popCnt;
    logic [OCC_W-1:0] freeBytes;
    logic [DW-1:0]    wrWord, rdWord;
    logic             ramWrEn;

    mb_byte_ram #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) uRam (
        .clk       (clk),
        .wrEn_i    (ramWrEn),
        .wrPtr_i   (wrPtr_q),
        .wrCount_i (pushCnt),
        .wrWord_i  (wrWord),
        .rdPtr_i   (rdPtr_q),
        .rdWord_o  (rdWord)
    );

    // Word-side strobes win arbitration; both limit checks use start-of-cycle
    // occupancy, so a same-cycle pop is never credited to a push or vice versa.
    always_comb begin
        wordCnt   = CNT_W'(size_to_bytes(32'(data_size)));
        wordPush  = store_tx_data && !buffer_reserved;
        bytePush  = store_rx_packet_data;
        pushReq   = wordPush || bytePush;
        pushCnt   = wordPush ? wordCnt : CNT_W'(1);
        wrWord    = wordPush ? tx_data : DW'(rx_packet_data);
        freeBytes = OCC_W'(DEPTH) - occ_q;
        pushOk    = pushReq && (OCC_W'(pushCnt) <= freeBytes);

        wordPop   = get_rx_data && !buffer_reserved;
        bytePop   = get_tx_packet_data;
        popReq    = wordPop || bytePop;
        popCnt    = wordPop ? wordCnt : CNT_W'(1);
        popOk     = popReq && (OCC_W'(popCnt) <= occ_q);

        ramWrEn   = pushOk && n_rst && !clear;
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        occ_d       = occ_q;
        rxData_d    = rxData_q;
        overflow_d  = overflow_q  || (pushReq && !pushOk);
        underflow_d = underflow_q || (popReq && !popOk);
        conflict_d  = conflict_q  || (wordPush && bytePush) || (wordPop && bytePop);

        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(pushCnt);
            occ_d   = occ_d + OCC_W'(pushCnt);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(popCnt);
            occ_d   = occ_d - OCC_W'(popCnt);
        end
        // Bytes beyond the requested access size read back as zero.
        if (popOk && wordPop) begin
            rxData_d = '0;
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (CNT_W'(k) < popCnt) begin
                    rxData_d[8*k +: 8] = rdWord[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            occ_q       <= '0;
            rxData_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            occ_q       <= occ_d;
            rxData_q    <= rxData_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            conflict_q  <= conflict_d;
        end
    end

    // The head byte is masked while empty because RAM contents are not reset.
    always_comb begin
        buffer_occupancy = occ_q;
        full             = (occ_q == OCC_W'(DEPTH));
        empty            = (occ_q == '0);
        rx_data          = rxData_q;
        tx_packet_data   = empty ? 8'h00 : rdWord[7:0];
        overflow_err     = overflow_q;
        underflow_err    = underflow_q;
        conflict_err     = conflict_q;
    end

endmodule
